// File: rtl/mask_bbox.sv
// mask_bbox: bounding box of horizontal mask runs of at least MIN_RUN pixels,
// accumulated over a frame and reported on each end-of-frame strobe.
module mask_bbox #(
  parameter int unsigned WIDTH     = 480,
  parameter int unsigned HEIGHT    = 640,
  parameter int unsigned MIN_RUN   = 4,
  parameter int unsigned MIN_COUNT = 64
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic        valid_in,
  input  logic        tabulate_in,
  output logic [10:0] left_out,
  output logic [10:0] right_out,
  output logic [9:0]  top_out,
  output logic [9:0]  bot_out,
  output logic [18:0] count_out,
  output logic        found_out,
  output logic        valid_out
);

  localparam int unsigned XW = 11;
  localparam int unsigned YW = 10;
  localparam int unsigned CW = 19;
  localparam int unsigned RW = 5;

  localparam logic [RW-1:0] RUN_MAX  = RW'(MIN_RUN);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [XW-1:0] X_EMPTY  = '1;
  localparam logic [YW-1:0] Y_EMPTY  = '1;

  typedef enum logic {ST_ACCUM = 1'b0, ST_REPORT = 1'b1} state_t;

  state_t          r_state;
  logic [XW-1:0]   r_prev_x;
  logic [YW-1:0]   r_prev_y;
  logic [RW-1:0]   r_run;
  logic [XW-1:0]   r_left;
  logic [XW-1:0]   r_right;
  logic [YW-1:0]   r_top;
  logic [YW-1:0]   r_bot;
  logic [CW-1:0]   r_count;

  logic            w_in_range;
  logic            w_adj;
  logic [RW-1:0]   w_run_next;
  logic            w_cont;
  logic            w_first;
  logic            w_qual;
  logic [XW-1:0]   w_left_cand;
  logic [CW:0]     w_inc;
  logic [CW:0]     w_count_sum;
  logic [CW-1:0]   w_count_next;
  logic            w_found;

  // Pixel qualification: range check, run continuation and run-length update
  always_comb begin
    w_in_range  = valid_in && (32'(x_in) < WIDTH) && (32'(y_in) < HEIGHT);
    w_adj       = (y_in == r_prev_y) &&
                  ({1'b0, x_in} == ({1'b0, r_prev_x} + 12'd1));
    w_run_next  = '0;
    if (w_in_range) begin
      if (w_adj) begin
        w_run_next = (r_run == RUN_MAX) ? RUN_MAX : r_run + RW'(1);
      end else begin
        w_run_next = RW'(1);
      end
    end
    // A continuing pixel of an already-qualified run adds one; the pixel that
    // first reaches MIN_RUN adds the whole run so far.
    w_cont      = w_in_range && w_adj && (r_run == RUN_MAX);
    w_qual      = (w_run_next == RUN_MAX);
    w_first     = w_qual && !w_cont;
    w_left_cand = x_in - XW'(MIN_RUN - 1);
    w_inc       = '0;
    if (w_first) begin
      w_inc = (CW+1)'(MIN_RUN);
    end else if (w_cont) begin
      w_inc = (CW+1)'(1);
    end
    w_count_sum  = {1'b0, r_count} + w_inc;
    w_count_next = w_count_sum[CW] ? CNT_MAX : w_count_sum[CW-1:0];
    w_found      = (32'(r_count) >= MIN_COUNT);
  end

  // Frame FSM, accumulators and registered report outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= ST_ACCUM;
      r_prev_x  <= '0;
      r_prev_y  <= '0;
      r_run     <= '0;
      r_left    <= X_EMPTY;
      r_right   <= '0;
      r_top     <= Y_EMPTY;
      r_bot     <= '0;
      r_count   <= '0;
      left_out  <= '0;
      right_out <= '0;
      top_out   <= '0;
      bot_out   <= '0;
      count_out <= '0;
      found_out <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      r_prev_x  <= x_in;
      r_prev_y  <= y_in;
      valid_out <= 1'b0;

      case (r_state)
        ST_ACCUM:  r_state <= tabulate_in ? ST_REPORT : ST_ACCUM;
        ST_REPORT: r_state <= tabulate_in ? ST_REPORT : ST_ACCUM;
        default:   r_state <= ST_ACCUM;
      endcase

      if (tabulate_in) begin
        // Close the frame: publish, then restart empty; this cycle's pixel is dropped
        valid_out <= 1'b1;
        count_out <= r_count;
        found_out <= w_found;
        if (w_found) begin
          left_out  <= r_left;
          right_out <= r_right;
          top_out   <= r_top;
          bot_out   <= r_bot;
        end
        r_run   <= '0;
        r_left  <= X_EMPTY;
        r_right <= '0;
        r_top   <= Y_EMPTY;
        r_bot   <= '0;
        r_count <= '0;
      end else begin
        r_run   <= w_run_next;
        r_count <= w_count_next;
        if (w_first && (w_left_cand < r_left)) r_left <= w_left_cand;
        if (w_qual) begin
          if (x_in > r_right) r_right <= x_in;
          if (y_in < r_top)   r_top   <= y_in;
          if (y_in > r_bot)   r_bot   <= y_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_mask_bbox.sv
// tb_mask_bbox: randomized and directed stimulus against a frame-level
// reference model; a scoreboard monitor checks every reported frame.
module tb_mask_bbox;

  localparam int unsigned WIDTH   = 480;
  localparam int unsigned HEIGHT  = 640;
  localparam int unsigned MIN_RUN = 4;
  localparam int unsigned MC0     = 64;
  localparam int unsigned MC1     = 8;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [10:0] x_in = '0;
  logic [9:0]  y_in = '0;
  logic        valid_in = 1'b0;
  logic        tabulate_in = 1'b0;

  logic [10:0] left_o  [2];
  logic [10:0] right_o [2];
  logic [9:0]  top_o   [2];
  logic [9:0]  bot_o   [2];
  logic [18:0] count_o [2];
  logic        found_o [2];
  logic        valid_o [2];

  mask_bbox #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .MIN_RUN(MIN_RUN), .MIN_COUNT(MC0)) dut0 (
    .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
    .valid_in(valid_in), .tabulate_in(tabulate_in),
    .left_out(left_o[0]), .right_out(right_o[0]), .top_out(top_o[0]), .bot_out(bot_o[0]),
    .count_out(count_o[0]), .found_out(found_o[0]), .valid_out(valid_o[0]));

  mask_bbox #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .MIN_RUN(MIN_RUN), .MIN_COUNT(MC1)) dut1 (
    .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
    .valid_in(valid_in), .tabulate_in(tabulate_in),
    .left_out(left_o[1]), .right_out(right_o[1]), .top_out(top_o[1]), .bot_out(bot_o[1]),
    .count_out(count_o[1]), .found_out(found_o[1]), .valid_out(valid_o[1]));

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    int unsigned count;
    bit          found;
    int unsigned l, r, t, b;
  } exp_t;

  typedef struct {
    bit inr;
    int x;
    int y;
  } pix_t;

  exp_t q0[$];
  exp_t q1[$];
  pix_t frame[$];
  int unsigned hold [2][4];

  int n_tests = 0;
  int n_fail  = 0;

  // frame summary scratch
  int m_cnt, m_l, m_r, m_t, m_b;
  int rs, rl, ry, rx;

  function automatic int unsigned mc(int k);
    return (k == 0) ? MC0 : MC1;
  endfunction

  task automatic chk(string name, int k, int unsigned act, int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d)", name, k, act, exp, cyc);
    end
  endtask

  task automatic close_run();
    if (rl >= int'(MIN_RUN)) begin
      m_cnt += rl;
      if (rs < m_l) m_l = rs;
      if (rx > m_r) m_r = rx;
      if (ry < m_t) m_t = ry;
      if (ry > m_b) m_b = ry;
    end
    rl = 0;
  endtask

  // Split the closed frame into maximal horizontal runs; long runs count whole
  task automatic report();
    exp_t e;
    m_cnt = 0; m_l = 2047; m_r = 0; m_t = 1023; m_b = 0;
    rl = 0; rs = 0; ry = 0; rx = 0;
    foreach (frame[i]) begin
      if (frame[i].inr && rl > 0 && frame[i].y == ry && frame[i].x == rx + 1) begin
        rl++;
        rx = frame[i].x;
      end else begin
        close_run();
        if (frame[i].inr) begin
          rs = frame[i].x; rl = 1; ry = frame[i].y; rx = frame[i].x;
        end
      end
    end
    close_run();
    if (m_cnt > 524287) m_cnt = 524287;
    for (int k = 0; k < 2; k++) begin
      e.cyc   = cyc + 1;
      e.count = m_cnt;
      e.found = (m_cnt >= int'(mc(k)));
      if (e.found) begin
        hold[k][0] = m_l; hold[k][1] = m_r; hold[k][2] = m_t; hold[k][3] = m_b;
      end
      e.l = hold[k][0]; e.r = hold[k][1]; e.t = hold[k][2]; e.b = hold[k][3];
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic model_step(bit rst, bit v, int x, int y, bit tab);
    if (rst) begin
      frame.delete();
      for (int k = 0; k < 2; k++) for (int j = 0; j < 4; j++) hold[k][j] = 0;
    end else if (tab) begin
      report();
      frame.delete();
    end else begin
      frame.push_back('{v && x < int'(WIDTH) && y < int'(HEIGHT), x, y});
    end
  endtask

  task automatic drive(bit v, int x, int y, bit tab, bit rst);
    @(negedge clk_in);
    rst_in      = rst;
    valid_in    = v;
    x_in        = 11'(x);
    y_in        = 10'(y);
    tabulate_in = tab;
    model_step(rst, v, x, y, tab);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic rect(int x0, int x1, int y0, int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) drive(1'b1, x, y, 1'b0, 1'b0);
  endtask

  task automatic tab();
    drive(1'b0, 0, 0, 1'b1, 1'b0);
  endtask

  // Scoreboard monitor: every reported frame must match the next expectation
  always @(negedge clk_in) begin
    for (int k = 0; k < 2; k++) begin
      if (valid_o[k] === 1'b1) begin
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid dut%0d: got valid_out=1 expected 0 (cycle %0d)", k, cyc);
        end else begin
          exp_t e;
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          chk("report_cycle", k, cyc, e.cyc);
          chk("count", k, int'(count_o[k]), e.count);
          chk("found", k, int'(found_o[k]), int'(e.found));
          chk("left", k, int'(left_o[k]), e.l);
          chk("right", k, int'(right_o[k]), e.r);
          chk("top", k, int'(top_o[k]), e.t);
          chk("bot", k, int'(bot_o[k]), e.b);
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) for (int j = 0; j < 4; j++) hold[k][j] = 0;

    // reset state
    drive(1'b1, 5, 5, 1'b0, 1'b1);
    drive(1'b1, 6, 5, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      chk("rst_left", k, int'(left_o[k]), 0);
      chk("rst_right", k, int'(right_o[k]), 0);
      chk("rst_top", k, int'(top_o[k]), 0);
      chk("rst_bot", k, int'(bot_o[k]), 0);
      chk("rst_count", k, int'(count_o[k]), 0);
      chk("rst_found", k, int'(found_o[k]), 0);
      chk("rst_valid", k, int'(valid_o[k]), 0);
    end
    idle(3);

    // solid rectangle
    rect(100, 119, 200, 209);
    tab();
    idle(2);

    // forty isolated 3-pixel runs
    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < 3; j++) drive(1'b1, 10 + (i % 10) * 5 + j, 20 + i / 10, 1'b0, 1'b0);
      drive(1'b0, 0, 0, 1'b0, 1'b0);
    end
    tab();
    idle(2);

    // single short row
    rect(30, 39, 50, 50);
    tab();
    idle(2);

    // edge of frame: runs split across rows and out-of-range pixels
    rect(478, 479, 5, 5);
    rect(0, 1, 6, 6);
    rect(474, 485, 10, 10);
    rect(10, 20, 640, 640);
    rect(100, 110, 700, 700);
    tab();
    idle(2);

    // pixel on the tabulate cycle, back-to-back tabulate, pixels during report
    rect(10, 13, 1, 1);
    drive(1'b1, 14, 1, 1'b1, 1'b0);
    drive(1'b1, 15, 1, 1'b1, 1'b0);
    rect(16, 19, 1, 1);
    tab();
    idle(2);

    // reset mid-rectangle, then reset coinciding with tabulate
    rect(200, 219, 300, 304);
    drive(1'b1, 220, 304, 1'b0, 1'b1);
    rect(200, 219, 300, 309);
    tab();
    idle(2);
    rect(50, 70, 60, 62);
    drive(1'b0, 0, 0, 1'b1, 1'b1);
    idle(2);
    rect(50, 70, 60, 62);
    tab();
    idle(2);

    // randomized frames
    for (int f = 0; f < 10; f++) begin
      int x0, y0, w, h;
      x0 = (f % 3 == 0) ? int'(WIDTH) - 12 : int'($urandom_range(0, WIDTH - 1));
      y0 = (f % 4 == 1) ? int'(HEIGHT) - 4 : int'($urandom_range(0, HEIGHT - 1));
      w  = int'($urandom_range(4, 30));
      h  = int'($urandom_range(1, 12));
      for (int yy = 0; yy < h; yy++)
        for (int xx = 0; xx < w; xx++)
          drive($urandom_range(0, 9) != 0, x0 + xx, y0 + yy,
                $urandom_range(0, 149) == 0, 1'b0);
      tab();
      if ($urandom_range(0, 2) == 0) tab();
      idle(int'($urandom_range(0, 3)));
    end

    idle(4);
    chk("pending_reports", 0, q0.size(), 0);
    chk("pending_reports", 1, q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
